// File: rtl/mem_wb_stage_pkg.sv
// ---------------------------------------------------------------------------
// mem_wb_stage_pkg
//   Shared definitions for the RV32IM MEM/WB stage: default widths,
//   writeback-source select codes and load funct3 codes.
// ---------------------------------------------------------------------------
package mem_wb_stage_pkg;

    localparam int unsigned XLEN_DEF   = 32;
    localparam int unsigned REG_AW_DEF = 5;
    localparam int unsigned CNT_W_DEF  = 64;

    // Writeback source select; 2'b11 is reserved and behaves as ALU.
    typedef enum logic [1:0] {
        WB_SEL_ALU  = 2'b00,
        WB_SEL_LOAD = 2'b01,
        WB_SEL_PC4  = 2'b10,
        WB_SEL_RSVD = 2'b11
    } wb_sel_e;

    // Load funct3 encodings; the unlisted codes behave as LW.
    typedef enum logic [2:0] {
        LOAD_F3_LB  = 3'b000,
        LOAD_F3_LH  = 3'b001,
        LOAD_F3_LW  = 3'b010,
        LOAD_F3_LBU = 3'b100,
        LOAD_F3_LHU = 3'b101
    } load_f3_e;

    // True for the halfword loads (signed or unsigned).
    function automatic logic is_half_load(input logic [2:0] funct3);
        return (funct3 == LOAD_F3_LH) || (funct3 == LOAD_F3_LHU);
    endfunction

    // True for the byte loads (signed or unsigned).
    function automatic logic is_byte_load(input logic [2:0] funct3);
        return (funct3 == LOAD_F3_LB) || (funct3 == LOAD_F3_LBU);
    endfunction

endpackage

// File: rtl/mem_wb_stage_load_align.sv
// ---------------------------------------------------------------------------
// load_align
//   Combinational load data alignment and extension.
//   Ports:
//     word       in  XLEN  raw aligned word from data memory
//     off        in  2     byte offset (effective address [1:0])
//     funct3     in  3     load type (LB/LH/LW/LBU/LHU, others as LW)
//     data       out XLEN  aligned, sign/zero-extended load result
//     misaligned out 1     access is not naturally aligned
// ---------------------------------------------------------------------------
module load_align
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] word,
    input  logic [1:0]      off,
    input  logic [2:0]      funct3,
    output logic [XLEN-1:0] data,
    output logic            misaligned
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[7:0];
        case (off)
            2'd0:    byte_v = word[7:0];
            2'd1:    byte_v = word[15:8];
            2'd2:    byte_v = word[23:16];
            default: byte_v = word[31:24];
        endcase
        half_v = off[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        data       = word;
        misaligned = 1'b0;
        case (funct3)
            LOAD_F3_LB: begin
                data = {{(XLEN-8){byte_v[7]}}, byte_v};
            end
            LOAD_F3_LBU: begin
                data = {{(XLEN-8){1'b0}}, byte_v};
            end
            LOAD_F3_LH: begin
                data       = {{(XLEN-16){half_v[15]}}, half_v};
                misaligned = off[0];
            end
            LOAD_F3_LHU: begin
                data       = {{(XLEN-16){1'b0}}, half_v};
                misaligned = off[0];
            end
            default: begin
                // LW and the undefined encodings take the whole word.
                data       = word;
                misaligned = (off != 2'b00);
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// ---------------------------------------------------------------------------
// mem_wb_stage
//   MEM/WB pipeline register and writeback logic of the RV32IM pipeline.
//   Captures the memory-stage result on posedge CLK, aligns/extends load
//   data, selects the writeback source and drives the register-file write
//   port, which commits on the following negedge. Flags misaligned loads
//   and counts retired instructions.
//   Ports:
//     CLK, RESET (sync, active high), STALL (hold), FLUSH (bubble)
//     MEM_VALID, MEM_REG_WRITE_EN, MEM_DEST_ADDR, MEM_WB_SEL,
//     MEM_LOAD_FUNCT3, MEM_ALU_RESULT, MEM_READ_DATA, MEM_PC   (MEM inputs)
//     WB_DATA, WB_DEST_ADDR, WB_WRITE_EN   -> register file write port
//     WB_VALID            retiring instruction present
//     WB_LOAD_MISALIGNED  registered misaligned-load flag
//     INSTRET             retired-instruction count (wraps)
// ---------------------------------------------------------------------------
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int unsigned XLEN   = XLEN_DEF,
    parameter int unsigned REG_AW = REG_AW_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic              MEM_VALID,
    input  logic              MEM_REG_WRITE_EN,
    input  logic [REG_AW-1:0] MEM_DEST_ADDR,
    input  logic [1:0]        MEM_WB_SEL,
    input  logic [2:0]        MEM_LOAD_FUNCT3,
    input  logic [XLEN-1:0]   MEM_ALU_RESULT,
    input  logic [XLEN-1:0]   MEM_READ_DATA,
    input  logic [XLEN-1:0]   MEM_PC,
    output logic [XLEN-1:0]   WB_DATA,
    output logic [REG_AW-1:0] WB_DEST_ADDR,
    output logic              WB_WRITE_EN,
    output logic              WB_VALID,
    output logic              WB_LOAD_MISALIGNED,
    output logic [CNT_W-1:0]  INSTRET
);

    logic [XLEN-1:0] load_data;
    logic            align_mis;
    logic            is_load;
    logic            load_mis;
    logic [XLEN-1:0] wb_data_next;
    logic            wb_we_next;

    load_align #(
        .XLEN (XLEN)
    ) u_load_align (
        .word       (MEM_READ_DATA),
        .off        (MEM_ALU_RESULT[1:0]),
        .funct3     (MEM_LOAD_FUNCT3),
        .data       (load_data),
        .misaligned (align_mis)
    );

    // Writeback source select; only an actual load can be misaligned.
    always_comb begin
        is_load      = (MEM_WB_SEL == WB_SEL_LOAD);
        load_mis     = is_load & align_mis;
        wb_data_next = MEM_ALU_RESULT;
        case (MEM_WB_SEL)
            WB_SEL_LOAD: wb_data_next = load_data;
            WB_SEL_PC4:  wb_data_next = MEM_PC + XLEN'(4);
            default:     wb_data_next = MEM_ALU_RESULT;
        endcase
        wb_we_next = MEM_VALID & MEM_REG_WRITE_EN &
                     (MEM_DEST_ADDR != '0) & ~load_mis;
    end

    // Pipeline registers: RESET > FLUSH > STALL > capture.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            WB_DATA            <= '0;
            WB_DEST_ADDR       <= '0;
            WB_WRITE_EN        <= 1'b0;
            WB_VALID           <= 1'b0;
            WB_LOAD_MISALIGNED <= 1'b0;
            INSTRET            <= '0;
        end else if (FLUSH) begin
            WB_DATA            <= '0;
            WB_DEST_ADDR       <= '0;
            WB_WRITE_EN        <= 1'b0;
            WB_VALID           <= 1'b0;
            WB_LOAD_MISALIGNED <= 1'b0;
        end else if (!STALL) begin
            WB_DATA            <= wb_data_next;
            WB_DEST_ADDR       <= MEM_DEST_ADDR;
            WB_WRITE_EN        <= wb_we_next;
            WB_VALID           <= MEM_VALID;
            WB_LOAD_MISALIGNED <= MEM_VALID & load_mis;
            if (MEM_VALID) begin
                INSTRET <= INSTRET + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
module tb_mem_wb_stage;

    localparam int XLEN = 32;
    localparam int AW   = 5;
    localparam int CW   = 8;

    logic            clk = 1'b0;
    logic            reset, stall, flush;
    logic            mem_valid, mem_we;
    logic [AW-1:0]   mem_rd;
    logic [1:0]      mem_sel;
    logic [2:0]      mem_f3;
    logic [XLEN-1:0] mem_alu, mem_rdata, mem_pc;
    logic [XLEN-1:0] wb_data;
    logic [AW-1:0]   wb_addr;
    logic            wb_we, wb_valid, wb_mis;
    logic [CW-1:0]   instret;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state (expected registered outputs).
    logic [31:0] m_data;
    logic [4:0]  m_addr;
    logic        m_we, m_valid, m_mis;
    int          m_cnt;

    mem_wb_stage #(.XLEN(XLEN), .REG_AW(AW), .CNT_W(CW)) dut (
        .CLK                (clk),
        .RESET              (reset),
        .STALL              (stall),
        .FLUSH              (flush),
        .MEM_VALID          (mem_valid),
        .MEM_REG_WRITE_EN   (mem_we),
        .MEM_DEST_ADDR      (mem_rd),
        .MEM_WB_SEL         (mem_sel),
        .MEM_LOAD_FUNCT3    (mem_f3),
        .MEM_ALU_RESULT     (mem_alu),
        .MEM_READ_DATA      (mem_rdata),
        .MEM_PC             (mem_pc),
        .WB_DATA            (wb_data),
        .WB_DEST_ADDR       (wb_addr),
        .WB_WRITE_EN        (wb_we),
        .WB_VALID           (wb_valid),
        .WB_LOAD_MISALIGNED (wb_mis),
        .INSTRET            (instret)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Load result from plain arithmetic on the byte offset.
    function automatic logic [31:0] ref_load(input logic [31:0] w, input int off, input int f3);
        longint uw = longint'(w);
        longint v;
        case (f3)
            0, 4: begin
                v = (uw >> (8 * off)) % 256;
                if (f3 == 0 && v >= 128) v = v - 256;
            end
            1, 5: begin
                v = (uw >> (16 * (off / 2))) % 65536;
                if (f3 == 1 && v >= 32768) v = v - 65536;
            end
            default: v = uw;
        endcase
        return v[31:0];
    endfunction

    function automatic bit ref_mis(input int off, input int f3);
        if (f3 == 0 || f3 == 4) return 1'b0;
        if (f3 == 1 || f3 == 5) return (off % 2) != 0;
        return off != 0;
    endfunction

    task automatic model_update();
        int  off;
        bit  mis;
        off = int'(mem_alu % 4);
        if (reset) begin
            m_data = 0; m_addr = 0; m_we = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
        end else if (flush) begin
            m_data = 0; m_addr = 0; m_we = 0; m_valid = 0; m_mis = 0;
        end else if (!stall) begin
            mis = (mem_sel == 2'd1) && ref_mis(off, int'(mem_f3));
            if (mem_sel == 2'd1)      m_data = ref_load(mem_rdata, off, int'(mem_f3));
            else if (mem_sel == 2'd2) m_data = mem_pc + 32'd4;
            else                      m_data = mem_alu;
            m_addr  = mem_rd;
            m_valid = mem_valid;
            m_mis   = mem_valid && mis;
            m_we    = mem_valid && mem_we && (mem_rd != 0) && !mis;
            if (mem_valid) m_cnt = (m_cnt + 1) % 256;
        end
    endtask

    task automatic cycle(input string tag);
        @(posedge clk);
        model_update();
        #1;
        chk({tag, ".data"},  64'(wb_data),  64'(m_data));
        chk({tag, ".addr"},  64'(wb_addr),  64'(m_addr));
        chk({tag, ".we"},    64'(wb_we),    64'(m_we));
        chk({tag, ".valid"}, 64'(wb_valid), 64'(m_valid));
        chk({tag, ".mis"},   64'(wb_mis),   64'(m_mis));
        chk({tag, ".cnt"},   64'(instret),  64'(m_cnt));
    endtask

    task automatic set_in(input logic v, input logic we, input logic [4:0] rd,
                          input logic [1:0] sel, input logic [2:0] f3,
                          input logic [31:0] alu, input logic [31:0] rdat,
                          input logic [31:0] pc);
        mem_valid = v; mem_we = we; mem_rd = rd; mem_sel = sel; mem_f3 = f3;
        mem_alu = alu; mem_rdata = rdat; mem_pc = pc;
    endtask

    initial begin
        m_data = 0; m_addr = 0; m_we = 0; m_valid = 0; m_mis = 0; m_cnt = 0;
        reset = 1'b1; stall = 1'b0; flush = 1'b0;
        set_in(1'b1, 1'b1, 5'd7, 2'd0, 3'd2, 32'hDEAD_BEEF, 32'h1111_2222, 32'h40);

        // Reset with active inputs
        cycle("rst1");
        cycle("rst2");
        chk("rst.data", 64'(wb_data), 64'h0);
        chk("rst.we",   64'(wb_we),   64'h0);
        chk("rst.cnt",  64'(instret), 64'h0);
        reset = 1'b0;

        // ALU writeback
        set_in(1'b1, 1'b1, 5'd5, 2'd0, 3'd0, 32'h1234_5678, 32'h0, 32'h0);
        cycle("alu");
        chk("alu.data_k", 64'(wb_data), 64'h1234_5678);
        chk("alu.addr_k", 64'(wb_addr), 64'd5);
        chk("alu.we_k",   64'(wb_we),   64'd1);
        chk("alu.cnt_k",  64'(instret), 64'd1);

        // Load alignment and extension
        set_in(1'b1, 1'b1, 5'd6, 2'd1, 3'b000, 32'h0000_1003, 32'h80FF_7F01, 32'h0);
        cycle("lb3");
        chk("lb3.k", 64'(wb_data), 64'hFFFF_FF80);
        set_in(1'b1, 1'b1, 5'd6, 2'd1, 3'b100, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
        cycle("lbu2");
        chk("lbu2.k", 64'(wb_data), 64'h0000_00FF);
        set_in(1'b1, 1'b1, 5'd6, 2'd1, 3'b001, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
        cycle("lh2");
        chk("lh2.k", 64'(wb_data), 64'hFFFF_80FF);
        set_in(1'b1, 1'b1, 5'd6, 2'd1, 3'b101, 32'h0000_1000, 32'h80FF_7F01, 32'h0);
        cycle("lhu0");
        chk("lhu0.k", 64'(wb_data), 64'h0000_7F01);

        // Misaligned loads
        set_in(1'b1, 1'b1, 5'd9, 2'd1, 3'b010, 32'h0000_1002, 32'h80FF_7F01, 32'h0);
        cycle("lwmis");
        chk("lwmis.mis_k",   64'(wb_mis),   64'd1);
        chk("lwmis.we_k",    64'(wb_we),    64'd0);
        chk("lwmis.valid_k", 64'(wb_valid), 64'd1);
        set_in(1'b1, 1'b1, 5'd9, 2'd1, 3'b001, 32'h0000_1001, 32'h80FF_7F01, 32'h0);
        cycle("lhmis");
        chk("lhmis.mis_k", 64'(wb_mis), 64'd1);
        chk("lhmis.we_k",  64'(wb_we),  64'd0);

        // rd = x0, then PC+4
        set_in(1'b1, 1'b1, 5'd0, 2'd0, 3'd0, 32'hAAAA_5555, 32'h0, 32'h0);
        cycle("x0");
        chk("x0.we_k", 64'(wb_we), 64'd0);
        set_in(1'b1, 1'b1, 5'd1, 2'd2, 3'd0, 32'h0, 32'h0, 32'h0000_0100);
        cycle("pc4");
        chk("pc4.k", 64'(wb_data), 64'h0000_0104);
        set_in(1'b1, 1'b1, 5'd1, 2'd2, 3'd0, 32'h0, 32'h0, 32'hFFFF_FFFC);
        cycle("pc4wrap");

        // STALL + FLUSH together gives a bubble
        stall = 1'b1; flush = 1'b1;
        cycle("stfl");
        chk("stfl.valid_k", 64'(wb_valid), 64'd0);
        stall = 1'b0; flush = 1'b0;
        set_in(1'b1, 1'b1, 5'd3, 2'd0, 3'd0, 32'h0BAD_F00D, 32'h0, 32'h0);
        cycle("prestall");

        // STALL alone for three cycles with changing inputs
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            set_in(1'b1, 1'b1, 5'(i + 10), 2'd0, 3'd0, $urandom, $urandom, $urandom);
            cycle("stall");
            chk("stall.data_k", 64'(wb_data), 64'h0BAD_F00D);
        end

        // Reset wins mid-stall
        reset = 1'b1;
        cycle("rststall");
        reset = 1'b0; stall = 1'b0;

        // Randomised traffic
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(0, 63) == 0);
            flush = ($urandom_range(0, 15) == 0);
            stall = ($urandom_range(0, 7) == 0);
            set_in($urandom_range(0, 3) != 0, 1'($urandom), 5'($urandom),
                   2'($urandom), 3'($urandom), $urandom, $urandom, $urandom);
            cycle("rand");
        end

        // Counter wrap
        reset = 1'b0; flush = 1'b0; stall = 1'b0;
        set_in(1'b1, 1'b1, 5'd2, 2'd0, 3'd0, 32'h5, 32'h0, 32'h0);
        for (int i = 0; i < 300 && m_cnt != 255; i++) cycle("fill");
        chk("prewrap.cnt_k", 64'(instret), 64'hFF);
        cycle("wrap");
        chk("wrap.cnt_k", 64'(instret), 64'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
